csr_trap_sequencer: RTL and testbench
=====================================

# csr_trap_sequencer

Controller that sequences trap entry and trap return into `CSR_FILE` for the RV32 machine-mode core. It arbitrates synchronous exceptions, `MRET` requests and the three machine interrupt lines (`MEIP`, `MSIP`, `MTIP`). It drains the pipeline, then pulses `TRAP`/`TRAP_RETURN` with a frozen cause and PC for exactly one cycle. It sits between the decode/execute stages and `CSR_FILE`, and hands the fetch stage a redirect PC taken from `HANDLER_PC`.

## Interface
Parameters:
- `DRAIN_MAX`, 16 — drain timeout in cycles; used only with `CSR_SEQ_DRAIN_TIMEOUT_EN`.
- `CNT_W`, 5 — width of the drain counter; must satisfy `2**CNT_W > DRAIN_MAX`.

Ports:
- `CLK` in 1 — single clock, rising edge.
- `RST` in 1 — reset, synchronous, active-high.
- `EXC_VALID` in 1 — exception request; held until `REQ_ACK`.
- `EXC_CODE` in 4 — exception cause code.
- `EXC_PC` in 32 — PC of the faulting instruction.
- `MRET_REQ` in 1 — trap-return request; held until `REQ_ACK`.
- `INT_PC` in 32 — PC of the oldest uncommitted instruction; this is the interrupt return point.
- `MEIP`, `MSIP`, `MTIP` in 1 each — interrupt pending levels.
- `MSTATUS_MIE` in 1 — global interrupt enable.
- `MIE_REG` in 32 — contents of the `mie` CSR.
- `PIPE_IDLE` in 1 — pipeline has drained.
- `HANDLER_PC` in 32 — from `CSR_FILE`; valid the cycle after `TRAP`/`TRAP_RETURN`.
- `FLUSH` out 1 — squash younger instructions and stall fetch.
- `TRAP` out 1 — one-cycle pulse to `CSR_FILE`.
- `TRAP_RETURN` out 1 — one-cycle pulse to `CSR_FILE`.
- `TRAP_PC` out 32 — PC to `CSR_FILE`.
- `E_CODE_C` out 30 — cause code to `CSR_FILE`.
- `TRAP_INT` out 1 — cause is an interrupt (mcause[31]).
- `REQ_ACK` out 1 — pulse on commit of an exception or `MRET`.
- `REDIRECT_VALID` out 1 — one-cycle pulse to fetch.
- `REDIRECT_PC` out 32 — fetch redirect target.
- `BUSY` out 1 — sequencer not in IDLE.
- `DRAIN_TIMEOUT` out 1 — sticky timeout flag.

## Operation
- States are IDLE, DRAIN, COMMIT and REDIRECT, encoded in 2 bits.
- Interrupt eligibility:
  - MEI eligible = `MSTATUS_MIE & MEIP & MIE_REG[11]`.
  - MSI eligible = `MSTATUS_MIE & MSIP & MIE_REG[3]`.
  - MTI eligible = `MSTATUS_MIE & MTIP & MIE_REG[7]`.
- Arbitration in IDLE, highest first:
  - `EXC_VALID` → cause `{0, EXC_CODE}`, PC = `EXC_PC`.
  - `MRET_REQ`.
  - MEI (code 11), then MSI (code 3), then MTI (code 7); cause has `TRAP_INT`=1, PC = `INT_PC`.
- On a win, the winner's kind, code and PC are latched, and the FSM moves IDLE→DRAIN.
  - The latched values are frozen until IDLE is re-entered.
  - An interrupt that deasserts during DRAIN is still taken.
- In DRAIN, `FLUSH`=1. The FSM moves to COMMIT on the first cycle with `PIPE_IDLE`=1.
- In COMMIT, exactly one of `TRAP`/`TRAP_RETURN` is 1. `REQ_ACK`=1 only when the winner was an exception or `MRET`. The FSM then moves to REDIRECT.
- In REDIRECT, `REDIRECT_VALID`=1 and `REDIRECT_PC` = `HANDLER_PC` sampled combinationally. The FSM then moves to IDLE.
- Requests arriving while `BUSY` are not arbitrated. Exceptions and `MRET` stay held by the requester; interrupts are level-sensitive and are re-evaluated in IDLE.
- `E_CODE_C` is the zero-extended 4-bit code. `TRAP_PC` and `E_CODE_C` are driven from the latch in every state; they are meaningful only in COMMIT.

## Timing
- Reset: every output is 0, state is IDLE, `DRAIN_TIMEOUT` is 0, and the latch is cleared.
  - `RST` in any state takes effect at the next edge and aborts with no `TRAP`, `TRAP_RETURN` or `REQ_ACK` pulse.
- Minimum latency with `PIPE_IDLE` already 1:
  - request sampled at edge N → `FLUSH` in cycle N+1;
  - COMMIT in N+2;
  - `REDIRECT_VALID` in N+3.
  - Minimum request-to-request spacing is 4 cycles.
- `FLUSH` stays high in DRAIN, COMMIT and REDIRECT, and drops in the first IDLE cycle.
- Simultaneous `EXC_VALID`, `MRET_REQ` and all interrupts: only the exception is taken. `MRET` is taken on a later pass; interrupts are taken after that if still eligible.
- Back-to-back: the cycle after REDIRECT is IDLE, where arbitration occurs. No request is accepted in the REDIRECT cycle itself.

## Configuration
- `CSR_SEQ_DRAIN_TIMEOUT_EN` defined:
  - A counter increments in DRAIN.
  - When the count reaches `DRAIN_MAX` without `PIPE_IDLE`, the FSM forces COMMIT and sets `DRAIN_TIMEOUT` (sticky until `RST`).
  - The counter clears on DRAIN entry.
- Not defined: no counter is built. DRAIN waits indefinitely and `DRAIN_TIMEOUT` is tied to 0.

## Structure
- The shared package `csr_pkg` holds:
  - the state encoding;
  - the exception/interrupt code constants (MEI=11, MSI=3, MTI=7, ECALL_M=11, BREAKPOINT=3);
  - the `mie` bit indices.
- One sub-module, `csr_int_prio`: combinational fixed-priority interrupt encoder producing `int_valid` and `int_code[3:0]`.
- The FSM, latch and optional timeout counter live in `csr_trap_sequencer`.

## Test plan
- `EXC_VALID`=1, `EXC_CODE`=2, `EXC_PC`=0x100, `PIPE_IDLE`=1:
  - `TRAP` pulses 2 cycles later with `E_CODE_C`=2, `TRAP_INT`=0, `TRAP_PC`=0x100;
  - `REQ_ACK` pulses with it;
  - `REDIRECT_PC` equals `HANDLER_PC` one cycle later.
- `MEIP`=`MTIP`=1, `MIE_REG`=0xFFFFFFFF, `MSTATUS_MIE`=1 → `E_CODE_C`=11, `TRAP_INT`=1, no `REQ_ACK`.
- `MTIP`=1 with `MIE_REG[7]`=0 → no `FLUSH` and `BUSY`=0 for 20 cycles.
- `EXC_VALID`, `MRET_REQ` and `MSIP` all asserted together:
  - `TRAP` with the exception code first;
  - `TRAP_RETURN` on the next pass;
  - `MSIP` is taken after that.
- `PIPE_IDLE` held 0 for 40 cycles:
  - with the macro and `DRAIN_MAX`=16, COMMIT occurs after 16 DRAIN cycles and `DRAIN_TIMEOUT`=1;
  - without the macro, the FSM is still in DRAIN at cycle 40.
- `RST` asserted in the DRAIN cycle → outputs 0 the next cycle, no `TRAP` pulse ever issued for that request.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode trap sequencer: FSM encoding,
// winner kinds, cause codes and mie bit positions.
package csr_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

  localparam logic [1:0] KIND_EXC  = 2'd0;
  localparam logic [1:0] KIND_MRET = 2'd1;
  localparam logic [1:0] KIND_INT  = 2'd2;

  localparam logic [3:0] CODE_MEI        = 4'd11;
  localparam logic [3:0] CODE_MSI        = 4'd3;
  localparam logic [3:0] CODE_MTI        = 4'd7;
  localparam logic [3:0] CODE_ECALL_M    = 4'd11;
  localparam logic [3:0] CODE_BREAKPOINT = 4'd3;

  localparam int MIE_MSIE = 3;
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  // mcause low field as seen by CSR_FILE: the 4-bit code zero-extended.
  function automatic logic [29:0] cause_ext(input logic [3:0] code);
    return {26'b0, code};
  endfunction

endpackage

// File: rtl/csr_int_prio.sv
// Fixed-priority machine interrupt encoder: MEI over MSI over MTI,
// all gated by the global mstatus.MIE enable.
module csr_int_prio
  import csr_pkg::*;
(
  input  logic       mstatus_mie,
  input  logic       meip,
  input  logic       msip,
  input  logic       mtip,
  input  logic       meie,
  input  logic       msie,
  input  logic       mtie,
  output logic       int_valid,
  output logic [3:0] int_code
);

  logic mei_ok;
  logic msi_ok;
  logic mti_ok;

  assign mei_ok = mstatus_mie & meip & meie;
  assign msi_ok = mstatus_mie & msip & msie;
  assign mti_ok = mstatus_mie & mtip & mtie;

  always_comb begin
    int_valid = 1'b0;
    int_code  = 4'd0;
    if (mei_ok) begin
      int_valid = 1'b1;
      int_code  = CODE_MEI;
    end else if (msi_ok) begin
      int_valid = 1'b1;
      int_code  = CODE_MSI;
    end else if (mti_ok) begin
      int_valid = 1'b1;
      int_code  = CODE_MTI;
    end
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Trap entry/return sequencer: arbitrate, drain the pipe, pulse CSR_FILE, redirect fetch.
// Optional drain watchdog enabled by defining CSR_SEQ_DRAIN_TIMEOUT_EN.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter int DRAIN_MAX = 16,
  parameter int CNT_W     = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EXC_VALID,
  input  logic [3:0]  EXC_CODE,
  input  logic [31:0] EXC_PC,
  input  logic        MRET_REQ,
  input  logic [31:0] INT_PC,
  input  logic        MEIP,
  input  logic        MSIP,
  input  logic        MTIP,
  input  logic        MSTATUS_MIE,
  input  logic [31:0] MIE_REG,
  input  logic        PIPE_IDLE,
  input  logic [31:0] HANDLER_PC,
  output logic        FLUSH,
  output logic        TRAP,
  output logic        TRAP_RETURN,
  output logic [31:0] TRAP_PC,
  output logic [29:0] E_CODE_C,
  output logic        TRAP_INT,
  output logic        REQ_ACK,
  output logic        REDIRECT_VALID,
  output logic [31:0] REDIRECT_PC,
  output logic        BUSY,
  output logic        DRAIN_TIMEOUT
);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [1:0]  lat_kind;
  logic [3:0]  lat_code;
  logic [31:0] lat_pc;
  logic        int_valid;
  logic [3:0]  int_code;
  logic        drain_expire;
  logic        unused_mie;

  assign unused_mie = ^{MIE_REG[31:12], MIE_REG[10:8], MIE_REG[6:4], MIE_REG[2:0]};

  csr_int_prio u_int_prio (
    .mstatus_mie (MSTATUS_MIE),
    .meip        (MEIP),
    .msip        (MSIP),
    .mtip        (MTIP),
    .meie        (MIE_REG[MIE_MEIE]),
    .msie        (MIE_REG[MIE_MSIE]),
    .mtie        (MIE_REG[MIE_MTIE]),
    .int_valid   (int_valid),
    .int_code    (int_code)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (EXC_VALID || MRET_REQ || int_valid) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (PIPE_IDLE || drain_expire) state_nxt = ST_COMMIT;
      ST_COMMIT:   state_nxt = ST_REDIRECT;
      ST_REDIRECT: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // The winner is captured only in IDLE, so the cause stays frozen even if an interrupt drops mid-drain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      lat_kind <= KIND_EXC;
      lat_code <= 4'd0;
      lat_pc   <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        if (EXC_VALID) begin
          lat_kind <= KIND_EXC;
          lat_code <= EXC_CODE;
          lat_pc   <= EXC_PC;
        end else if (MRET_REQ) begin
          lat_kind <= KIND_MRET;
          lat_code <= 4'd0;
          lat_pc   <= 32'd0;
        end else if (int_valid) begin
          lat_kind <= KIND_INT;
          lat_code <= int_code;
          lat_pc   <= INT_PC;
        end
      end
    end
  end

`ifdef CSR_SEQ_DRAIN_TIMEOUT_EN
  logic [CNT_W-1:0] drain_cnt;
  logic             timeout_q;

  assign drain_expire  = (state == ST_DRAIN) && (drain_cnt == CNT_W'(DRAIN_MAX - 1));
  assign DRAIN_TIMEOUT = timeout_q;

  // Counter sits at zero in IDLE so every DRAIN visit starts a fresh count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      drain_cnt <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_DRAIN) drain_cnt <= drain_cnt + CNT_W'(1);
      else                   drain_cnt <= '0;
      if (drain_expire && !PIPE_IDLE) timeout_q <= 1'b1;
    end
  end
`else
  localparam int unused_cfg = DRAIN_MAX + CNT_W;
  assign drain_expire  = 1'b0;
  assign DRAIN_TIMEOUT = 1'b0;
`endif

  assign FLUSH          = (state != ST_IDLE);
  assign BUSY           = (state != ST_IDLE);
  assign TRAP           = (state == ST_COMMIT) && (lat_kind != KIND_MRET);
  assign TRAP_RETURN    = (state == ST_COMMIT) && (lat_kind == KIND_MRET);
  assign REQ_ACK        = (state == ST_COMMIT) && (lat_kind != KIND_INT);
  assign REDIRECT_VALID = (state == ST_REDIRECT);
  assign REDIRECT_PC    = REDIRECT_VALID ? HANDLER_PC : 32'd0;
  assign TRAP_PC        = lat_pc;
  assign E_CODE_C       = cause_ext(lat_code);
  assign TRAP_INT       = (lat_kind == KIND_INT);

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed, table-driven bench for csr_trap_sequencer; timeout checks follow
// whether CSR_SEQ_DRAIN_TIMEOUT_EN is defined.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] exc_pc;
  logic        mret_req;
  logic [31:0] int_pc;
  logic        meip, msip, mtip;
  logic        mstatus_mie;
  logic [31:0] mie_reg;
  logic        pipe_idle;
  logic [31:0] handler_pc;
  logic        flush, trap, trap_return, trap_int, req_ack;
  logic        redirect_valid, busy, drain_timeout;
  logic [31:0] trap_pc, redirect_pc;
  logic [29:0] e_code_c;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        exc;
    logic [3:0]  code;
    logic [31:0] epc;
    logic        mret;
    logic        meip;
    logic        msip;
    logic        mtip;
    logic        gie;
    logic [31:0] mie;
    logic [31:0] ipc;
    logic        take;
    logic        exp_trap;
    logic        exp_ret;
    logic        exp_int;
    logic [3:0]  exp_code;
    logic [31:0] exp_pc;
    logic        exp_ack;
  } vec_t;

  vec_t vecs[10];

  csr_trap_sequencer #(.DRAIN_MAX(16), .CNT_W(5)) dut (
    .CLK(clk), .RST(rst),
    .EXC_VALID(exc_valid), .EXC_CODE(exc_code), .EXC_PC(exc_pc),
    .MRET_REQ(mret_req), .INT_PC(int_pc),
    .MEIP(meip), .MSIP(msip), .MTIP(mtip),
    .MSTATUS_MIE(mstatus_mie), .MIE_REG(mie_reg),
    .PIPE_IDLE(pipe_idle), .HANDLER_PC(handler_pc),
    .FLUSH(flush), .TRAP(trap), .TRAP_RETURN(trap_return),
    .TRAP_PC(trap_pc), .E_CODE_C(e_code_c), .TRAP_INT(trap_int),
    .REQ_ACK(req_ack), .REDIRECT_VALID(redirect_valid),
    .REDIRECT_PC(redirect_pc), .BUSY(busy), .DRAIN_TIMEOUT(drain_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passed++;
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_flush"}, {31'd0, flush}, 32'd0);
    checkOutput({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({pfx, "_trap"}, {31'd0, trap}, 32'd0);
    checkOutput({pfx, "_trap_return"}, {31'd0, trap_return}, 32'd0);
    checkOutput({pfx, "_req_ack"}, {31'd0, req_ack}, 32'd0);
    checkOutput({pfx, "_trap_int"}, {31'd0, trap_int}, 32'd0);
    checkOutput({pfx, "_trap_pc"}, trap_pc, 32'd0);
    checkOutput({pfx, "_e_code_c"}, {2'b0, e_code_c}, 32'd0);
    checkOutput({pfx, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
    checkOutput({pfx, "_redirect_pc"}, redirect_pc, 32'd0);
    checkOutput({pfx, "_drain_timeout"}, {31'd0, drain_timeout}, 32'd0);
  endtask

  task automatic clearRequests();
    exc_valid = 1'b0;
    exc_code  = 4'd0;
    exc_pc    = 32'd0;
    mret_req  = 1'b0;
    meip      = 1'b0;
    msip      = 1'b0;
    mtip      = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exc_valid   = v.exc;
    exc_code    = v.code;
    exc_pc      = v.epc;
    mret_req    = v.mret;
    meip        = v.meip;
    msip        = v.msip;
    mtip        = v.mtip;
    mstatus_mie = v.gie;
    mie_reg     = v.mie;
    int_pc      = v.ipc;
  endtask

  task automatic runVector(input int idx, input vec_t v);
    logic seen_busy;
    logic [31:0] hpc;
    string p;
    p = $sformatf("v%0d", idx);
    hpc = 32'h8000_0000 + 32'(idx * 16);
    handler_pc = hpc;
    applyStimulus(v);
    tick();
    if (!v.take) begin
      seen_busy = busy | flush;
      for (int k = 0; k < 19; k++) begin
        tick();
        seen_busy = seen_busy | busy | flush;
      end
      checkOutput({p, "_never_busy"}, {31'd0, seen_busy}, 32'd0);
      clearRequests();
      return;
    end
    checkOutput({p, "_drain_flush"}, {31'd0, flush}, 32'd1);
    checkOutput({p, "_drain_no_trap"}, {31'd0, trap | trap_return}, 32'd0);
    // Interrupt lines drop during DRAIN; the latched winner must still commit.
    clearRequests();
    tick();
    checkOutput({p, "_trap"}, {31'd0, trap}, {31'd0, v.exp_trap});
    checkOutput({p, "_trap_return"}, {31'd0, trap_return}, {31'd0, v.exp_ret});
    checkOutput({p, "_req_ack"}, {31'd0, req_ack}, {31'd0, v.exp_ack});
    if (!v.exp_ret) begin
      checkOutput({p, "_trap_int"}, {31'd0, trap_int}, {31'd0, v.exp_int});
      checkOutput({p, "_e_code_c"}, {2'b0, e_code_c}, {28'd0, v.exp_code});
      checkOutput({p, "_trap_pc"}, trap_pc, v.exp_pc);
    end
    tick();
    checkOutput({p, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd1);
    checkOutput({p, "_redirect_pc"}, redirect_pc, hpc);
    checkOutput({p, "_redirect_no_trap"}, {31'd0, trap}, 32'd0);
    tick();
    checkOutput({p, "_idle_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({p, "_idle_flush"}, {31'd0, flush}, 32'd0);
  endtask

  initial begin
    int evt;
    int last_commit;
    int commit_at;
    logic to_before;
    logic seen_trap;

    //            exc   code   epc            mret  meip  msip  mtip  gie   mie            ipc            take  trap  ret   int   code   pc             ack
    vecs[0] = '{1'b1, 4'd2,  32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_1000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  32'h0000_0100, 1'b1};
    vecs[1] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_2000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd11, 32'h0000_2000, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF7F, 32'h0000_2004, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  32'h0,         1'b0};
    vecs[3] = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_2008, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  32'h0,         1'b1};
    vecs[4] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'h0000_200C, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  32'h0000_200C, 1'b0};
    vecs[5] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_2010, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7,  32'h0000_2010, 1'b0};
    vecs[6] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_2014, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3,  32'h0000_2014, 1'b0};
    vecs[7] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_2018, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  32'h0,         1'b0};
    vecs[8] = '{1'b1, 4'd11, 32'h0000_0204, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_201C, 1'b1, 1'b1, 1'b0, 1'b0, 4'd11, 32'h0000_0204, 1'b1};
    vecs[9] = '{1'b1, 4'd3,  32'h0000_0208, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_2020, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  32'h0000_0208, 1'b1};

    rst = 1'b1;
    clearRequests();
    int_pc      = 32'd0;
    mstatus_mie = 1'b0;
    mie_reg     = 32'd0;
    pipe_idle   = 1'b1;
    handler_pc  = 32'hDEAD_0000;
    @(negedge clk);
    tick();
    tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) runVector(i, vecs[i]);

    // Exception, MRET and MSIP together: three passes, four cycles apart, in priority order.
    exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h0000_0300;
    mret_req = 1'b1; msip = 1'b1; mstatus_mie = 1'b1; mie_reg = 32'hFFFF_FFFF;
    int_pc = 32'h0000_0400; handler_pc = 32'h0000_0800;
    evt = 0;
    last_commit = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (trap || trap_return) begin
        case (evt)
          0: begin
            checkOutput("simul_first_trap", {31'd0, trap}, 32'd1);
            checkOutput("simul_first_code", {2'b0, e_code_c}, 32'd5);
            checkOutput("simul_first_int", {31'd0, trap_int}, 32'd0);
            checkOutput("simul_first_pc", trap_pc, 32'h0000_0300);
          end
          1: begin
            checkOutput("simul_second_ret", {31'd0, trap_return}, 32'd1);
            checkOutput("simul_second_ack", {31'd0, req_ack}, 32'd1);
            checkOutput("simul_second_gap", 32'(c - last_commit), 32'd4);
          end
          2: begin
            checkOutput("simul_third_trap", {31'd0, trap}, 32'd1);
            checkOutput("simul_third_code", {2'b0, e_code_c}, 32'd3);
            checkOutput("simul_third_int", {31'd0, trap_int}, 32'd1);
            checkOutput("simul_third_ack", {31'd0, req_ack}, 32'd0);
            checkOutput("simul_third_gap", 32'(c - last_commit), 32'd4);
          end
          default: checkOutput("simul_extra_commit", 32'd1, 32'd0);
        endcase
        evt++;
        last_commit = c;
      end
      if (req_ack) begin
        if (exc_valid) exc_valid = 1'b0;
        else           mret_req  = 1'b0;
      end
      if (trap && trap_int) msip = 1'b0;
    end
    checkOutput("simul_event_count", 32'(evt), 32'd3);
    clearRequests();
    tick();

    // Pipeline never drains.
    pipe_idle = 1'b0;
    exc_valid = 1'b1; exc_code = 4'd1; exc_pc = 32'h0000_0600;
    tick();
    exc_valid = 1'b0;
    commit_at = 0;
    to_before = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (trap && commit_at == 0) commit_at = k;
      if (k == 16) to_before = drain_timeout;
      if (k < 40) tick();
    end
`ifdef CSR_SEQ_DRAIN_TIMEOUT_EN
    checkOutput("timeout_commit_cycle", 32'(commit_at), 32'd17);
    checkOutput("timeout_flag_before", {31'd0, to_before}, 32'd0);
    checkOutput("timeout_flag_sticky", {31'd0, drain_timeout}, 32'd1);
    checkOutput("timeout_back_idle", {31'd0, busy}, 32'd0);
    pipe_idle = 1'b1;
    tick();
`else
    checkOutput("no_timeout_commit", 32'(commit_at), 32'd0);
    checkOutput("no_timeout_busy", {31'd0, busy}, 32'd1);
    checkOutput("no_timeout_flush", {31'd0, flush}, 32'd1);
    checkOutput("no_timeout_flag", {31'd0, drain_timeout}, 32'd0);
    pipe_idle = 1'b1;
    tick();
    checkOutput("late_drain_trap", {31'd0, trap}, 32'd1);
    checkOutput("late_drain_code", {2'b0, e_code_c}, 32'd1);
    tick();
    tick();
`endif

    // Reset while draining aborts the request silently and clears the sticky flag.
    pipe_idle = 1'b0;
    exc_valid = 1'b1; exc_code = 4'd9; exc_pc = 32'h0000_0500;
    tick();
    checkOutput("rst_drain_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    exc_valid = 1'b0;
    tick();
    checkAllZero("rst_drain");
    rst = 1'b0;
    pipe_idle = 1'b1;
    seen_trap = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen_trap = seen_trap | trap | req_ack;
    end
    checkOutput("rst_drain_no_trap_after", {31'd0, seen_trap}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
